// File: rtl/multicycle_decoder.sv
// Main control decoder for the multicycle CPU: a Moore sequencer that steers the
// datapath and raises unconditioned write requests for the condition-logic stage.
module multicycle_decoder (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic [1:0] FlagW,
    output logic       PCS,
    output logic       RegW,
    output logic       MemW,
    output logic       NextPC,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    state_t     state_r;
    state_t     state_next_s;
    logic       alu_op_s;
    logic       branch_s;
    logic       cmd_valid_s;
    logic       add_sub_s;

    // State register; reset drops straight back to FETCH without waiting for an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; unused encodings recover to FETCH.
    always_comb begin
        state_next_s = FETCH;
        case (state_r)
            FETCH:    state_next_s = DECODE;
            DECODE: begin
                case (Op)
                    2'b00:   state_next_s = Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_next_s = MEMADR;
                    2'b10:   state_next_s = BRANCH;
                    default: state_next_s = FETCH;
                endcase
            end
            MEMADR:   state_next_s = Funct[0] ? MEMRD : MEMWR;
            MEMRD:    state_next_s = MEMWB;
            EXECUTER: state_next_s = ALUWB;
            EXECUTEI: state_next_s = ALUWB;
            default:  state_next_s = FETCH;
        endcase
    end

    // Moore per-state datapath controls.
    always_comb begin
        NextPC    = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        RegW      = 1'b0;
        MemW      = 1'b0;
        alu_op_s  = 1'b0;
        branch_s  = 1'b0;
        case (state_r)
            FETCH: begin
                NextPC    = 1'b1;
                IRWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR:   ALUSrcB = 2'b01;
            MEMRD:    AdrSrc  = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            EXECUTER: alu_op_s = 1'b1;
            EXECUTEI: begin
                ALUSrcB  = 2'b01;
                alu_op_s = 1'b1;
            end
            ALUWB:    RegW = 1'b1;
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch_s  = 1'b1;
            end
            default: begin
                NextPC = 1'b0;
            end
        endcase
    end

    // ALU decode; unsupported commands fall back to ADD and never request a flag write.
    always_comb begin
        ALUControl  = 2'b00;
        cmd_valid_s = 1'b0;
        add_sub_s   = 1'b0;
        if (alu_op_s) begin
            case (Funct[4:1])
                4'b0100: begin ALUControl = 2'b00; cmd_valid_s = 1'b1; add_sub_s = 1'b1; end
                4'b0010: begin ALUControl = 2'b01; cmd_valid_s = 1'b1; add_sub_s = 1'b1; end
                4'b0000: begin ALUControl = 2'b10; cmd_valid_s = 1'b1; end
                4'b1100: begin ALUControl = 2'b11; cmd_valid_s = 1'b1; end
                default: begin ALUControl = 2'b00; end
            endcase
        end else begin
            ALUControl = 2'b00;
        end
    end

    assign FlagW  = cmd_valid_s ? {Funct[0], Funct[0] & add_sub_s} : 2'b00;
    assign PCS    = branch_s | (RegW & (Rd == 4'hF));
    assign ImmSrc = Op;
    assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};
    assign State  = state_r;

endmodule

// File: tb/tb_multicycle_decoder.sv
// Scoreboard bench for multicycle_decoder: the driver queues hand-written per-cycle
// expectations, a negedge monitor pops and compares them against the DUT outputs.
module tb_multicycle_decoder;

    logic       clk;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NextPC;
    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] ResultSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUControl;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [3:0] State;

    typedef struct {
        logic [22:0] vec;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   errors;
    logic mon_en;

    multicycle_decoder dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
        .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NextPC(NextPC),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
        .State(State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // fields: flagw pcs regw memw nextpc irwrite adrsrc resultsrc srca srcb aluctl immsrc regsrc
    task automatic push(input string tag, input logic [3:0] st, input logic [1:0] fw,
                        input logic pcs, input logic regw, input logic memw,
                        input logic npc, input logic irw, input logic adr,
                        input logic [1:0] res, input logic sa, input logic [1:0] sb,
                        input logic [1:0] ac, input logic [1:0] imm, input logic [1:0] rs);
        exp_t e;
        e.vec = {fw, pcs, regw, memw, npc, irw, adr, res, sa, sb, ac, imm, rs, st};
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic p_fetch(input string tag, input logic [1:0] imm, input logic [1:0] rs);
        push({tag, "/fetch"}, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
             2'b10, 1'b1, 2'b10, 2'b00, imm, rs);
    endtask

    task automatic p_decode(input string tag, input logic [1:0] imm, input logic [1:0] rs);
        push({tag, "/decode"}, 4'd1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
             2'b10, 1'b1, 2'b10, 2'b00, imm, rs);
    endtask

    task automatic run_instr(input logic [1:0] op, input logic [5:0] fn,
                             input logic [3:0] rd, input int n);
        Op    = op;
        Funct = fn;
        Rd    = rd;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: one expected entry per cycle while the scoreboard is armed.
    always @(negedge clk) begin
        if (mon_en) begin
            if (q.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL underflow: got state %h expected no output", State);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk(e.tag, {9'd0, FlagW, PCS, RegW, MemW, NextPC, IRWrite, AdrSrc, ResultSrc,
                            ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, State},
                    {9'd0, e.vec});
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        mon_en = 1'b0;
        reset  = 1'b1;
        Op     = 2'b00;
        Funct  = 6'b000000;
        Rd     = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {28'd0, State}, 32'd0);
        chk("reset_fetch_ctl", {30'd0, NextPC, IRWrite}, 32'd3);
        chk("reset_writes", {27'd0, FlagW, PCS, RegW, MemW}, 32'd0);

        // Start an LDR, then hit reset asynchronously in the middle of it.
        reset = 1'b0;
        Op    = 2'b01;
        Funct = 6'b011001;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_reset_state", {28'd0, State}, 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_state", {28'd0, State}, 32'd0);
        chk("async_reset_writes", {27'd0, FlagW, PCS, RegW, MemW}, 32'd0);
        @(posedge clk);
        #1;
        chk("held_reset_state", {28'd0, State}, 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // ADD register form, Rd=2
        p_fetch("add", 2'b00, 2'b00);
        p_decode("add", 2'b00, 2'b00);
        push("add/execr", 4'd6, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        push("add/aluwb", 4'd8, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        run_instr(2'b00, 6'b001000, 4'd2, 4);

        // SUBS immediate, Rd=3
        p_fetch("subs", 2'b00, 2'b00);
        p_decode("subs", 2'b00, 2'b00);
        push("subs/execi", 4'd7, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00);
        push("subs/aluwb", 4'd8, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        run_instr(2'b00, 6'b100101, 4'd3, 4);

        // ANDS register form: logical op sets only NZ
        p_fetch("ands", 2'b00, 2'b00);
        p_decode("ands", 2'b00, 2'b00);
        push("ands/execr", 4'd6, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00);
        push("ands/aluwb", 4'd8, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        run_instr(2'b00, 6'b000001, 4'd1, 4);

        // Unsupported cmd 0001 with S=1: ADD, no flag write
        p_fetch("eors", 2'b00, 2'b00);
        p_decode("eors", 2'b00, 2'b00);
        push("eors/execr", 4'd6, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        push("eors/aluwb", 4'd8, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        run_instr(2'b00, 6'b000011, 4'd5, 4);

        // LDR
        p_fetch("ldr", 2'b01, 2'b10);
        p_decode("ldr", 2'b01, 2'b10);
        push("ldr/memadr", 4'd2, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 2'b01, 2'b10);
        push("ldr/memrd",  4'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 2'b10);
        push("ldr/memwb",  4'd4, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 2'b01, 2'b10);
        run_instr(2'b01, 6'b011001, 4'd4, 5);

        // STR
        p_fetch("str", 2'b01, 2'b10);
        p_decode("str", 2'b01, 2'b10);
        push("str/memadr", 4'd2, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 2'b01, 2'b10);
        push("str/memwr",  4'd5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 2'b10);
        run_instr(2'b01, 6'b011000, 4'd4, 4);

        // Branch
        p_fetch("b", 2'b10, 2'b01);
        p_decode("b", 2'b10, 2'b01);
        push("b/branch", 4'd9, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b01, 2'b00, 2'b10, 2'b01);
        run_instr(2'b10, 6'b000000, 4'd0, 3);

        // ORR writing R15
        p_fetch("orr", 2'b00, 2'b00);
        p_decode("orr", 2'b00, 2'b00);
        push("orr/execr", 4'd6, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b11, 2'b00, 2'b00);
        push("orr/aluwb", 4'd8, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        run_instr(2'b00, 6'b011000, 4'd15, 4);

        // Undefined op: straight back to fetch, no writes
        p_fetch("und", 2'b11, 2'b00);
        p_decode("und", 2'b11, 2'b00);
        run_instr(2'b11, 6'b111111, 4'd15, 2);

        // Back in FETCH after the undefined op
        p_fetch("post", 2'b00, 2'b00);
        Op = 2'b00;
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        chk("queue_drained", q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_decoder.md
# multicycle_decoder

Main control decoder for the multicycle CPU. It sequences every instruction through a Moore state machine: fetch, decode, execute, memory and writeback. It produces the datapath steering signals plus the unconditioned write requests (FlagW, PCS, RegW, MemW) that the downstream condition-logic stage gates with the condition check. NextPC is produced here and bypasses condition gating.

## Interface
Parameters:
- none

Ports (name, direction, width, meaning):
- clk, input, 1: system clock; all state changes on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- Op, input, 2: instruction[27:26].
  - 00: data-processing.
  - 01: memory.
  - 10: branch.
- Funct, input, 6: instruction[25:20].
  - [5]: I (immediate).
  - [4:1]: cmd.
  - [0]: S, or L for memory instructions.
- Rd, input, 4: instruction[15:12].
- FlagW, output, 2: flag-write request. [1] covers NZ, [0] covers CV.
- PCS, output, 1: PC-from-result request (branch, or write to R15).
- RegW, output, 1: register-write request.
- MemW, output, 1: memory-write request.
- NextPC, output, 1: unconditional PC increment write.
- IRWrite, output, 1: instruction register load.
- AdrSrc, output, 1: memory address select. 0 = PC, 1 = ALU result.
- ResultSrc, output, 2: result select. 00 = ALUOut, 01 = ReadData, 10 = ALUResult.
- ALUSrcA, output, 1: ALU A select. 0 = register A, 1 = PC.
- ALUSrcB, output, 2: ALU B select. 00 = register, 01 = extended immediate, 10 = constant 4.
- ALUControl, output, 2: ALU operation. 00 ADD, 01 SUB, 10 AND, 11 ORR.
- ImmSrc, output, 2: immediate format; equals Op.
- RegSrc, output, 2: register-read address select.
- State, output, 4: current state, for debug and verification.

## Operation
State encoding:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9.
- Codes 10–15 are illegal and go to FETCH on the next edge.

Transitions:
- FETCH goes to DECODE.
- DECODE dispatches on Op and Funct:
  - Op=01 goes to MEMADR.
  - Op=00 with Funct[5]=0 goes to EXECUTER.
  - Op=00 with Funct[5]=1 goes to EXECUTEI.
  - Op=10 goes to BRANCH.
  - Op=11 goes to FETCH (undefined instruction, no side effects).
- MEMADR: Funct[0]=1 goes to MEMRD; otherwise MEMWR.
- MEMRD goes to MEMWB, then FETCH.
- MEMWR goes to FETCH.
- EXECUTER and EXECUTEI go to ALUWB, then FETCH.
- BRANCH goes to FETCH.

Per-state outputs (Moore). Any output not listed is 0.
- FETCH: NextPC=1, IRWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- MEMADR: ALUSrcA=0, ALUSrcB=01.
- MEMRD: AdrSrc=1, ResultSrc=00.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWR: AdrSrc=1, ResultSrc=00, MemW=1.
- EXECUTER: ALUSrcA=0, ALUSrcB=00, internal ALUOp=1.
- EXECUTEI: ALUSrcA=0, ALUSrcB=01, internal ALUOp=1.
- ALUWB: ResultSrc=00, RegW=1.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, internal Branch=1.

ALU decode, combinational:
- When ALUOp=0, ALUControl=00 and FlagW=00.
- When ALUOp=1, cmd selects the operation:
  - 0100 gives 00 (ADD).
  - 0010 gives 01 (SUB).
  - 0000 gives 10 (AND).
  - 1100 gives 11 (ORR).
  - Any other cmd gives ALUControl=00 with FlagW forced to 00.
- FlagW[1]=S. FlagW[0]=S & (ADD|SUB).

PC and instruction-field logic:
- PCS = Branch | (RegW & Rd==4'hF).
- ImmSrc = Op.
- RegSrc[0] = (Op==10).
- RegSrc[1] = (Op==01).

Op, Funct and Rd come from the instruction register and are stable from DECODE onward. The block does not latch them.

## Timing
- Reset:
  - Asserting reset forces State=FETCH immediately, without waiting for a clock edge, including mid-instruction.
  - During reset, outputs take the FETCH values: NextPC=1, IRWrite=1, all write requests 0.
  - First edge after deassertion moves to DECODE.
- Per-instruction cycle counts:
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - Data-processing: 4 cycles.
  - Branch: 3 cycles.
  - Undefined: 2 cycles.
- Outputs are pure functions of State plus the instruction fields: no output registers, zero extra latency.
- RegW, MemW, PCS and FlagW are each asserted for exactly one cycle per instruction, or never.
- In ALUWB with Rd=15: RegW=1 and PCS=1 in the same cycle.

## Test plan
- Reset then ADD register form:
  - Stimulus: assert reset mid-state, release; Op=00, Funct=001000 (ADD, S=0), Rd=2.
  - Required: State = 0→1→6→8→0.
  - In state 6: ALUControl=00, FlagW=00, ALUSrcB=00.
  - In state 8: RegW=1, PCS=0.
- SUBS immediate:
  - Stimulus: Op=00, Funct=100101, Rd=3.
  - Required: State 1→7.
  - In state 7: ALUControl=01, FlagW=11, ALUSrcB=01.
- LDR:
  - Stimulus: Op=01, Funct=011001.
  - Required: State 0,1,2,3,4,0.
  - In state 3: AdrSrc=1.
  - In state 4: ResultSrc=01, RegW=1.
  - RegSrc=10 and ImmSrc=01 throughout.
- STR:
  - Stimulus: Op=01, Funct=011000.
  - Required: State 0,1,2,5,0.
  - In state 5: MemW=1, AdrSrc=1, RegW=0.
- Branch:
  - Stimulus: Op=10.
  - Required: State 0,1,9,0.
  - In state 9: PCS=1, ResultSrc=10, ALUSrcB=01.
  - RegSrc=01.
- ORR writing PC, then undefined op:
  - Stimulus: Op=00, Funct=011000 (ORR), Rd=15.
  - Required in ALUWB: RegW=1, PCS=1, ALUControl=00, FlagW=00.
  - Follow-up stimulus: Op=11.
  - Required: State 1→0, with no write requests asserted.
